data_path: RTL and testbench

8-bit datapath for the processor. It holds PC, MAR, IR, A, B and CCR, the two-bus interconnect and the ALU. It sits opposite the control unit: it receives that unit's load, increment, select and ALU-select strobes and returns IR and CCR_Result to it. It drives the memory address and write-data lines and receives memory read data.

---
 rtl/cpu_pkg.sv | 50 +++++
 rtl/alu_8bit.sv | 58 +++++
 rtl/data_path.sv | 118 +++++++++++
 tb/tb_data_path.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the datapath and control unit: select encodings,
// opcode constants and condition-code bit positions.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CCR_W  = 4;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_INC  = 3'b100,
    ALU_DEC  = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_PASS = 3'b111
  } alu_sel_e;

  typedef enum logic [1:0] {
    BUS1_PC   = 2'b00,
    BUS1_A    = 2'b01,
    BUS1_B    = 2'b10,
    BUS1_ZERO = 2'b11
  } bus1_sel_e;

  typedef enum logic [1:0] {
    BUS2_ALU  = 2'b00,
    BUS2_BUS1 = 2'b01,
    BUS2_MEM  = 2'b10,
    BUS2_ZERO = 2'b11
  } bus2_sel_e;

  localparam logic [7:0] OP_LDA_IMM = 8'h01;
  localparam logic [7:0] OP_LDA_DIR = 8'h02;
  localparam logic [7:0] OP_BRA     = 8'h20;
  localparam logic [7:0] OP_BMI     = 8'h21;
  localparam logic [7:0] OP_BPL     = 8'h22;
  localparam logic [7:0] OP_BEQ     = 8'h23;
  localparam logic [7:0] OP_BNE     = 8'h24;
  localparam logic [7:0] OP_BVS     = 8'h25;
  localparam logic [7:0] OP_BVC     = 8'h26;
  localparam logic [7:0] OP_BCS     = 8'h27;
  localparam logic [7:0] OP_BCC     = 8'h28;

  localparam int unsigned CCR_N = 3;
  localparam int unsigned CCR_Z = 2;
  localparam int unsigned CCR_V = 1;
  localparam int unsigned CCR_C = 0;

endpackage

// File: rtl/alu_8bit.sv
// Combinational ALU: X (Bus1) and Y (B) in, result and {N,Z,V,C} out.
module alu_8bit
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] X,
  input  logic [DATA_W-1:0] Y,
  input  logic [2:0]        ALU_Sel,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        NZVC
);

  localparam int unsigned MSB = DATA_W - 1;

  logic [DATA_W:0]   wide;
  logic [DATA_W-1:0] opnd;
  logic              v_flag;
  logic              c_flag;

  // Operation select; INC/DEC reuse the add/sub paths with a constant 1 operand.
  always_comb begin
    wide   = '0;
    opnd   = Y;
    v_flag = 1'b0;
    c_flag = 1'b0;
    case (alu_sel_e'(ALU_Sel))
      ALU_ADD, ALU_INC: begin
        if (alu_sel_e'(ALU_Sel) == ALU_INC) opnd = {{(DATA_W-1){1'b0}}, 1'b1};
        wide   = {1'b0, X} + {1'b0, opnd};
        c_flag = wide[DATA_W];
        v_flag = (X[MSB] == opnd[MSB]) && (wide[MSB] != X[MSB]);
      end
      ALU_SUB, ALU_DEC: begin
        if (alu_sel_e'(ALU_Sel) == ALU_DEC) opnd = {{(DATA_W-1){1'b0}}, 1'b1};
        wide   = {1'b0, X} - {1'b0, opnd};
        c_flag = wide[DATA_W];
        v_flag = (X[MSB] != opnd[MSB]) && (wide[MSB] != X[MSB]);
      end
      ALU_AND:  wide = {1'b0, X & Y};
      ALU_OR:   wide = {1'b0, X | Y};
      ALU_XOR:  wide = {1'b0, X ^ Y};
      ALU_PASS: wide = {1'b0, X};
      default:  wide = '0;
    endcase
  end

  // Result and flag packing.
  always_comb begin
    result        = wide[DATA_W-1:0];
    NZVC          = '0;
    NZVC[CCR_N]   = wide[MSB];
    NZVC[CCR_Z]   = (wide[DATA_W-1:0] == '0);
    NZVC[CCR_V]   = v_flag;
    NZVC[CCR_C]   = c_flag;
  end

endmodule

// File: rtl/data_path.sv
// 8-bit processor datapath: PC, MAR, IR, A, B, CCR, two-bus interconnect,
// ALU and branch-condition decode for the control unit.
module data_path
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CCR_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              IR_Load,
  input  logic              MAR_Load,
  input  logic              PC_Load,
  input  logic              PC_Inc,
  input  logic              A_Load,
  input  logic              B_Load,
  input  logic [2:0]        ALU_Sel,
  input  logic              CCR_Load,
  input  logic [1:0]        Bus1_Sel,
  input  logic [1:0]        Bus2_Sel,
  input  logic [DATA_W-1:0] from_memory,
  output logic [DATA_W-1:0] IR,
  output logic              CCR_Result,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] to_memory
);

  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] mar;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [CCR_W-1:0]  ccr;
  logic [DATA_W-1:0] bus1;
  logic [DATA_W-1:0] bus2;
  logic [DATA_W-1:0] alu_result;
  logic [3:0]        alu_nzvc;

  alu_8bit #(.DATA_W(DATA_W)) u_alu (
    .X       (bus1),
    .Y       (b_reg),
    .ALU_Sel (ALU_Sel),
    .result  (alu_result),
    .NZVC    (alu_nzvc)
  );

  // Bus1 source select; the spare code drives zero.
  always_comb begin
    bus1 = '0;
    case (bus1_sel_e'(Bus1_Sel))
      BUS1_PC:   bus1 = pc;
      BUS1_A:    bus1 = a_reg;
      BUS1_B:    bus1 = b_reg;
      BUS1_ZERO: bus1 = '0;
      default:   bus1 = '0;
    endcase
  end

  // Bus2 source select; the spare code drives zero.
  always_comb begin
    bus2 = '0;
    case (bus2_sel_e'(Bus2_Sel))
      BUS2_ALU:  bus2 = alu_result;
      BUS2_BUS1: bus2 = bus1;
      BUS2_MEM:  bus2 = from_memory;
      BUS2_ZERO: bus2 = '0;
      default:   bus2 = '0;
    endcase
  end

  // Program counter: a load overrides an increment; increment wraps silently.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)       pc <= '0;
    else if (PC_Load) pc <= bus2;
    else if (PC_Inc)  pc <= pc + 1'b1;
  end

  // Bus2-loaded registers; all capture the same pre-edge Bus2 value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mar   <= '0;
      IR    <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      if (MAR_Load) mar   <= bus2;
      if (IR_Load)  IR    <= bus2;
      if (A_Load)   a_reg <= bus2;
      if (B_Load)   b_reg <= bus2;
    end
  end

  // Condition codes captured from the ALU regardless of the Bus2 source.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        ccr <= '0;
    else if (CCR_Load) ccr <= alu_nzvc;
  end

  // Branch condition for the opcode held in IR.
  always_comb begin
    CCR_Result = 1'b0;
    case (IR)
      OP_BRA:  CCR_Result = 1'b1;
      OP_BMI:  CCR_Result = ccr[CCR_N];
      OP_BPL:  CCR_Result = !ccr[CCR_N];
      OP_BEQ:  CCR_Result = ccr[CCR_Z];
      OP_BNE:  CCR_Result = !ccr[CCR_Z];
      OP_BVS:  CCR_Result = ccr[CCR_V];
      OP_BVC:  CCR_Result = !ccr[CCR_V];
      OP_BCS:  CCR_Result = ccr[CCR_C];
      OP_BCC:  CCR_Result = !ccr[CCR_C];
      default: CCR_Result = 1'b0;
    endcase
  end

  assign address   = mar;
  assign to_memory = bus1;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus random cycles,
// compared against an arithmetic reference model of the datapath.
module tb_data_path;

  logic       clock;
  logic       reset;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [7:0] from_memory;
  logic [7:0] IR;
  logic       CCR_Result;
  logic [7:0] address;
  logic [7:0] to_memory;

  int checks   = 0;
  int failures = 0;

  // reference state
  int m_pc, m_mar, m_ir, m_a, m_b;
  int m_n, m_z, m_v, m_c;

  data_path #(.DATA_W(8), .CCR_W(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .IR_Load     (IR_Load),
    .MAR_Load    (MAR_Load),
    .PC_Load     (PC_Load),
    .PC_Inc      (PC_Inc),
    .A_Load      (A_Load),
    .B_Load      (B_Load),
    .ALU_Sel     (ALU_Sel),
    .CCR_Load    (CCR_Load),
    .Bus1_Sel    (Bus1_Sel),
    .Bus2_Sel    (Bus2_Sel),
    .from_memory (from_memory),
    .IR          (IR),
    .CCR_Result  (CCR_Result),
    .address     (address),
    .to_memory   (to_memory)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
    m_n = 0; m_z = 0; m_v = 0; m_c = 0;
  endfunction

  function automatic int m_bus1();
    case (Bus1_Sel)
      2'd0:    return m_pc;
      2'd1:    return m_a;
      2'd2:    return m_b;
      default: return 0;
    endcase
  endfunction

  function automatic int to_signed8(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction

  // ALU from plain integer arithmetic; flags from signed/unsigned range tests.
  function automatic void model_alu(input int op, input int x, input int y,
                                    output int r, output int n, output int z,
                                    output int v, output int c);
    int full, sres;
    full = 0; sres = 0; v = 0; c = 0;
    case (op)
      0: begin full = x + y; sres = to_signed8(x) + to_signed8(y); c = (full > 255); end
      1: begin full = x - y; sres = to_signed8(x) - to_signed8(y); c = (x < y);      end
      2: full = x & y;
      3: full = x | y;
      4: begin full = x + 1; sres = to_signed8(x) + 1; c = (full > 255); end
      5: begin full = x - 1; sres = to_signed8(x) - 1; c = (x < 1);      end
      6: full = x ^ y;
      default: full = x;
    endcase
    if (op == 0 || op == 1 || op == 4 || op == 5) v = (sres > 127 || sres < -128);
    r = full & 255;
    n = (r >= 128);
    z = (r == 0);
  endfunction

  function automatic int m_branch();
    case (m_ir)
      32'h20: return 1;
      32'h21: return m_n;
      32'h22: return 1 - m_n;
      32'h23: return m_z;
      32'h24: return 1 - m_z;
      32'h25: return m_v;
      32'h26: return 1 - m_v;
      32'h27: return m_c;
      32'h28: return 1 - m_c;
      default: return 0;
    endcase
  endfunction

  task automatic idle();
    IR_Load = 0; MAR_Load = 0; PC_Load = 0; PC_Inc = 0;
    A_Load = 0; B_Load = 0; CCR_Load = 0;
    ALU_Sel = 3'd0; Bus1_Sel = 2'd0; Bus2_Sel = 2'd0; from_memory = 8'h00;
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic step();
    int b1, b2, r, n, z, v, c;
    #1;
    b1 = m_bus1();
    model_alu(int'(ALU_Sel), b1, m_b, r, n, z, v, c);
    case (Bus2_Sel)
      2'd0:    b2 = r;
      2'd1:    b2 = b1;
      2'd2:    b2 = int'(from_memory);
      default: b2 = 0;
    endcase
    check("to_memory", to_memory, 8'(b1));
    check("ccr_result_pre", {7'd0, CCR_Result}, 8'(m_branch()));
    @(posedge clock);
    if (reset) begin
      if (PC_Load)     m_pc = b2;
      else if (PC_Inc) m_pc = (m_pc + 1) % 256;
      if (MAR_Load) m_mar = b2;
      if (IR_Load)  m_ir  = b2;
      if (A_Load)   m_a   = b2;
      if (B_Load)   m_b   = b2;
      if (CCR_Load) begin m_n = n; m_z = z; m_v = v; m_c = c; end
    end
    #1;
    check("ir", IR, 8'(m_ir));
    check("address", address, 8'(m_mar));
    check("ccr_result", {7'd0, CCR_Result}, 8'(m_branch()));
    check("to_memory_post", to_memory, 8'(m_bus1()));
  endtask

  task automatic load_reg(input int which, input logic [7:0] val);
    idle();
    from_memory = val; Bus2_Sel = 2'd2;
    if (which == 0) A_Load = 1;
    else if (which == 1) B_Load = 1;
    else if (which == 2) IR_Load = 1;
    else PC_Load = 1;
    step();
  endtask

  initial begin
    idle();
    reset = 0;
    model_reset();
    #1;
    check("rst_address", address, 8'h00);
    check("rst_ir", IR, 8'h00);
    check("rst_to_memory", to_memory, 8'h00);
    check("rst_ccr_result", {7'd0, CCR_Result}, 8'h00);
    @(posedge clock); #1;
    reset = 1;

    // fetch
    idle(); from_memory = 8'h21; Bus1_Sel = 2'd0; Bus2_Sel = 2'd1; MAR_Load = 1; step();
    check("fetch_mar", address, 8'h00);
    idle(); from_memory = 8'h21; PC_Inc = 1; step();
    check("fetch_pc", to_memory, 8'h01);
    idle(); from_memory = 8'h21; Bus2_Sel = 2'd2; IR_Load = 1; step();
    check("fetch_ir", IR, 8'h21);

    // PC wrap and load priority
    load_reg(3, 8'hFF);
    idle(); PC_Inc = 1; step();
    check("pc_wrap", to_memory, 8'h00);
    idle(); PC_Inc = 1; PC_Load = 1; Bus2_Sel = 2'd2; from_memory = 8'h42; step();
    check("pc_load_prio", to_memory, 8'h42);

    // ADD overflow and branches
    load_reg(0, 8'h7F);
    load_reg(1, 8'h01);
    idle(); Bus1_Sel = 2'd1; ALU_Sel = 3'd0; Bus2_Sel = 2'd0; A_Load = 1; CCR_Load = 1; step();
    check("add_a", to_memory, 8'h80);
    load_reg(2, 8'h21); check("add_bmi", {7'd0, CCR_Result}, 8'h01);
    load_reg(2, 8'h25); check("add_bvs", {7'd0, CCR_Result}, 8'h01);
    load_reg(2, 8'h23); check("add_beq", {7'd0, CCR_Result}, 8'h00);

    // SUB zero and borrow
    load_reg(0, 8'h05);
    load_reg(1, 8'h05);
    idle(); Bus1_Sel = 2'd1; ALU_Sel = 3'd1; CCR_Load = 1; step();
    load_reg(2, 8'h23); check("sub_beq", {7'd0, CCR_Result}, 8'h01);
    load_reg(2, 8'h24); check("sub_bne", {7'd0, CCR_Result}, 8'h00);
    load_reg(0, 8'h00);
    load_reg(1, 8'h01);
    idle(); Bus1_Sel = 2'd1; ALU_Sel = 3'd1; CCR_Load = 1; step();
    load_reg(2, 8'h27); check("sub_bcs", {7'd0, CCR_Result}, 8'h01);
    load_reg(2, 8'h21); check("sub_bmi", {7'd0, CCR_Result}, 8'h01);

    // store path, constant bus, old-B semantics
    load_reg(1, 8'h3C);
    idle(); Bus1_Sel = 2'd2; #1;
    check("store_b", to_memory, 8'h3C);
    step();
    load_reg(0, 8'h55);
    idle(); Bus1_Sel = 2'd1; Bus2_Sel = 2'd3; A_Load = 1; step();
    check("const_zero_a", to_memory, 8'h00);
    load_reg(0, 8'h10);
    load_reg(1, 8'h05);
    idle(); Bus1_Sel = 2'd1; ALU_Sel = 3'd0; Bus2_Sel = 2'd0; B_Load = 1; step();
    idle(); Bus1_Sel = 2'd2; step();
    check("old_b", to_memory, 8'h15);

    // asynchronous reset mid-cycle with every load asserted
    idle();
    IR_Load = 1; MAR_Load = 1; PC_Load = 1; A_Load = 1; B_Load = 1; CCR_Load = 1;
    Bus2_Sel = 2'd2; from_memory = 8'h99;
    reset = 0;
    model_reset();
    #1;
    check("arst_address", address, 8'h00);
    check("arst_ir", IR, 8'h00);
    check("arst_to_memory", to_memory, 8'h00);
    check("arst_ccr_result", {7'd0, CCR_Result}, 8'h00);
    step();
    step();
    check("arst_hold_ir", IR, 8'h00);
    idle();
    reset = 1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      IR_Load     = ($urandom_range(0, 3) == 0);
      MAR_Load    = ($urandom_range(0, 3) == 0);
      PC_Load     = ($urandom_range(0, 5) == 0);
      PC_Inc      = ($urandom_range(0, 2) == 0);
      A_Load      = ($urandom_range(0, 2) == 0);
      B_Load      = ($urandom_range(0, 2) == 0);
      CCR_Load    = ($urandom_range(0, 1) == 0);
      ALU_Sel     = 3'($urandom_range(0, 7));
      Bus1_Sel    = 2'($urandom_range(0, 3));
      Bus2_Sel    = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) from_memory = 8'($urandom_range(8'h20, 8'h29));
      else                           from_memory = 8'($urandom_range(0, 255));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
